ft_tx_arbiter: RTL and testbench
================================

// Module: ft_tx_arbiter
// PURPOSE
//  Round-robin arbiter sharing the ft600_mode245 TX FIFO write port (tx_en/tx_in/tx_full)
//  between N_SRC stream producers (e.g. count_feeder-style sources). Each grant sends one
//  framed packet: one header word, then BURST_LEN payload words from the granted source.
//  Sits between the producers and ft600_mode245 in the clk domain; the host demuxes by header.
// PARAMETERS
//  N_SRC      2   number of requesters, 1..4
//  BURST_LEN  16  payload words per packet, 1..256
// PORTS
//  clk        in   1         system clock; all logic on posedge
//  rst        in   1         asynchronous, active-high reset
//  enable     in   1         1 = new grants allowed; 0 = finish current packet, then hold IDLE
//  src_req    in   N_SRC     per-source burst request; level, sampled only in IDLE
//  src_valid  in   N_SRC     per-source payload word valid
//  src_data   in   16*N_SRC  payload; source i on [16*i+15:16*i]
//  src_ready  out  N_SRC     payload word of source i accepted at this edge if valid&ready
//  tx_en      out  1         FIFO write strobe, to ft600_mode245 tx_en
//  tx_data    out  16        FIFO write data, to ft600_mode245 tx_in
//  tx_full    in   1         FIFO full, from ft600_mode245
//  busy       out  1         1 in HEADER or DATA
//  grant      out  N_SRC     one-hot granted source, 0 in IDLE
//  pkt_count  out  16        completed packets since reset, wraps 65535->0
// BEHAVIOUR
//  - Single clock clk; reset is asynchronous and active-high (rst). While rst=1: state IDLE,
//    busy=0, grant=0, tx_en=0, src_ready=0, tx_data=0, pkt_count=0, word counter=0,
//    all seq[i]=0, last-granted pointer = N_SRC-1 (so source 0 wins the first tie).
//  - Transfer rule: one FIFO word is written at a posedge iff tx_en=1. tx_en is
//    combinational and never 1 while tx_full=1. No write is ever lost or duplicated.
//  - FSM states: IDLE, HEADER, DATA.
//  - IDLE: tx_en=0, src_ready=0. If enable=1 and src_req!=0 at an edge, pick winner by
//    round-robin: first requesting index scanning upward from last_granted+1 (mod N_SRC).
//    Latch grant, go HEADER. Single requester wins every time. enable=0 with pending
//    requests -> stay IDLE.
//  - HEADER: tx_data = {4'hA, 2'b00, id[1:0], seq[id][7:0]}; tx_en = ~tx_full.
//    On transfer: word counter=0, go DATA.
//  - DATA: tx_data = src_data of granted source; src_ready[g] = ~tx_full, others 0;
//    tx_en = src_valid[g] & ~tx_full.
//    - Each transfer increments the word counter. src_valid low stalls without timeout.
//    - Transfer with counter==BURST_LEN-1 -> IDLE; same edge: seq[g]++ (8-bit wrap 255->0),
//      pkt_count++, last_granted=g.
//  - Latency: req sampled at edge k in IDLE -> header on the bus in the cycle after edge k;
//    written at edge k+1 if tx_full=0. Back-to-back packets cost 1 idle cycle (IDLE state).
//  - src_req changes during HEADER/DATA are ignored. Dropping src_req mid-packet does not
//    abort. enable=0 mid-packet does not abort.
//  - tx_full rising mid-packet: tx_en/src_ready drop in the same cycle; resume on deassert.
//  - tx_data holds its last value when tx_en=0; only reset clears it.
//  - Reset mid-packet: immediate return to IDLE; partial packet left in FIFO (host resyncs
//    on 4'hA header + length).
//  - grant, busy are registered state decodes (glitch-free); tx_en/src_ready are comb.
// TESTING
//  1 Reset: rst pulse mid-DATA -> tx_en=0, grant=0, busy=0, pkt_count=0 immediately, no edge needed.
//  2 Single source 0, BURST_LEN=4, data 1..4, tx_full=0 -> FIFO gets A000,1,2,3,4; next packet header A001.
//  3 Both src_req=11 held -> grants alternate 01,10,01,...; headers A000,A100,A001,A101; pkt_count=4 after 4 packets.
//  4 tx_full toggled every other cycle during DATA -> no write while full; payload order intact, count exact.
//  5 src_valid gaps in DATA, enable=0 mid-packet -> packet completes with BURST_LEN words, then IDLE; no new grant while enable=0.
//  6 256 packets from source 1 -> header seq wraps A1FF -> A100; pkt_count=256.

Source files
------------

// File: rtl/ft_tx_arbiter.sv
// Round-robin arbiter sharing one 16-bit FIFO write port between N_SRC stream producers.
// Each grant emits a header word {4'hA, 2'b00, id, seq} followed by BURST_LEN payload words.
module ft_tx_arbiter #(
   parameter int N_SRC     = 2,
   parameter int BURST_LEN = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [N_SRC-1:0]     src_req,
   input  logic [N_SRC-1:0]     src_valid,
   input  logic [16*N_SRC-1:0]  src_data,
   output logic [N_SRC-1:0]     src_ready,
   output logic                 tx_en,
   output logic [15:0]          tx_data,
   input  logic                 tx_full,
   output logic                 busy,
   output logic [N_SRC-1:0]     grant,
   output logic [15:0]          pkt_count
);

   localparam int        IW       = 2;
   localparam logic [7:0] LAST_WORD = 8'(BURST_LEN - 1);

   typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

   state_t            state_q, state_d;
   logic [N_SRC-1:0]  grant_q, grant_d;
   logic [IW-1:0]     gidx_q, gidx_d;
   logic [IW-1:0]     last_q, last_d;
   logic [7:0]        wcnt_q, wcnt_d;
   logic [7:0]        seq_q [4];
   logic [7:0]        seq_d [4];
   logic [15:0]       pkt_q, pkt_d;
   logic              busy_q, busy_d;
   logic [15:0]       txd_q, txd_d;

   logic [15:0]       sel_data;
   logic              sel_valid;
   logic [IW-1:0]     rr_idx, idx_hi, idx_lo;
   logic              found_hi;
   logic [15:0]       word;

   // Payload mux of the granted source
   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
         if (grant_q[i]) begin
            sel_data  = src_data[16*i +: 16];
            sel_valid = src_valid[i];
         end
      end
   end

   // Rotating priority: lowest requester above last_q, else lowest requester overall
   always_comb begin
      idx_hi   = '0;
      idx_lo   = '0;
      found_hi = 1'b0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (src_req[i]) begin
            idx_lo = IW'(i);
            if (IW'(i) > last_q) begin
               idx_hi   = IW'(i);
               found_hi = 1'b1;
            end
         end
      end
      rr_idx = found_hi ? idx_hi : idx_lo;
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      gidx_d    = gidx_q;
      last_d    = last_q;
      wcnt_d    = wcnt_q;
      seq_d     = seq_q;
      pkt_d     = pkt_q;
      busy_d    = busy_q;
      tx_en     = 1'b0;
      src_ready = '0;
      word      = '0;

      case (state_q)
         IDLE: begin
            if (enable && (|src_req)) begin
               state_d = HEADER;
               gidx_d  = rr_idx;
               grant_d = N_SRC'(1) << rr_idx;
               busy_d  = 1'b1;
            end
         end
         HEADER: begin
            word  = {4'hA, 2'b00, gidx_q, seq_q[gidx_q]};
            tx_en = ~tx_full;
            if (tx_en) begin
               wcnt_d  = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            word      = sel_data;
            src_ready = grant_q & {N_SRC{~tx_full}};
            tx_en     = sel_valid & ~tx_full;
            if (tx_en) begin
               if (wcnt_q == LAST_WORD) begin
                  state_d        = IDLE;
                  grant_d        = '0;
                  busy_d         = 1'b0;
                  seq_d[gidx_q]  = seq_q[gidx_q] + 8'd1;
                  pkt_d          = pkt_q + 16'd1;
                  last_d         = gidx_q;
               end else begin
                  wcnt_d = wcnt_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
         end
      endcase

      // Bus holds the last written word while idle or stalled
      txd_d   = tx_en ? word : txd_q;
      tx_data = txd_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         last_q  <= IW'(N_SRC - 1);
         wcnt_q  <= '0;
         for (int i = 0; i < 4; i++) seq_q[i] <= '0;
         pkt_q   <= '0;
         busy_q  <= 1'b0;
         txd_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         last_q  <= last_d;
         wcnt_q  <= wcnt_d;
         seq_q   <= seq_d;
         pkt_q   <= pkt_d;
         busy_q  <= busy_d;
         txd_q   <= txd_d;
      end
   end

   assign busy      = busy_q;
   assign grant     = grant_q;
   assign pkt_count = pkt_q;

endmodule

// File: tb/tb_ft_tx_arbiter.sv
// Directed bench for ft_tx_arbiter (N_SRC=2, BURST_LEN=4): captures every FIFO write
// and compares against hand-computed packet streams.
module tb_ft_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [1:0]  src_req;
   logic [1:0]  src_valid;
   logic [31:0] src_data;
   logic [1:0]  src_ready;
   logic        tx_en;
   logic [15:0] tx_data;
   logic        tx_full;
   logic        busy;
   logic [1:0]  grant;
   logic [15:0] pkt_count;

   int n_vec = 0;
   int n_bad = 0;
   int base;

   logic [15:0] cnt0, cnt1;
   logic [15:0] cap[$];
   logic [1:0]  gcap[$];
   logic [15:0] exp_q[$];

   ft_tx_arbiter #(.N_SRC(2), .BURST_LEN(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .src_req   (src_req),
      .src_valid (src_valid),
      .src_data  (src_data),
      .src_ready (src_ready),
      .tx_en     (tx_en),
      .tx_data   (tx_data),
      .tx_full   (tx_full),
      .busy      (busy),
      .grant     (grant),
      .pkt_count (pkt_count)
   );

   always #5 clk = ~clk;

   // Sources: source 0 counts 1,2,3..., source 1 counts 0x1001,0x1002,...
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (src_valid[0] && src_ready[0]) cnt0 <= cnt0 + 16'd1;
         if (src_valid[1] && src_ready[1]) cnt1 <= cnt1 + 16'd1;
      end
   end
   assign src_data = {16'h1000 + cnt1 + 16'd1, cnt0 + 16'd1};

   always @(posedge clk) begin
      if (tx_en) begin
         cap.push_back(tx_data);
         gcap.push_back(grant);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic check_seq(input string tag);
      chk({tag, "_len"}, 32'(cap.size() - base), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         chk($sformatf("%s[%0d]", tag, i), {16'h0, cap[base + i]}, {16'h0, exp_q[i]});
   endtask

   task automatic wait_pkt(input string tag, input logic [15:0] target, input int budget,
                           input bit toggle);
      for (int c = 0; c < budget && pkt_count !== target; c++) begin
         @(negedge clk);
         if (toggle) begin
            tx_full = ~tx_full;
            #1;
            if (tx_full) begin
               chk({tag, "_full_no_en"}, {31'h0, tx_en}, 32'h0);
               chk({tag, "_full_no_rdy"}, {30'h0, src_ready}, 32'h0);
            end
         end
      end
      chk({tag, "_pkt"}, {16'h0, pkt_count}, {16'h0, target});
   endtask

   initial begin
      rst       = 1'b1;
      enable    = 1'b0;
      src_req   = 2'b00;
      src_valid = 2'b00;
      tx_full   = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_tx_en", {31'h0, tx_en}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_grant", {30'h0, grant}, 32'h0);
      chk("rst_ready", {30'h0, src_ready}, 32'h0);
      chk("rst_tx_data", {16'h0, tx_data}, 32'h0);
      chk("rst_pkt", {16'h0, pkt_count}, 32'h0);
      rst = 1'b0;

      // Single source 0: two packets, latency of first header
      @(negedge clk);
      base      = cap.size();
      enable    = 1'b1;
      src_valid = 2'b11;
      src_req   = 2'b01;
      @(negedge clk);
      chk("t2_busy", {31'h0, busy}, 32'h1);
      chk("t2_grant", {30'h0, grant}, 32'h1);
      chk("t2_hdr_en", {31'h0, tx_en}, 32'h1);
      chk("t2_hdr", {16'h0, tx_data}, 32'hA000);
      wait_pkt("t2", 16'd2, 40, 1'b0);
      src_req = 2'b00;
      exp_q = '{16'hA000, 16'd1, 16'd2, 16'd3, 16'd4, 16'hA001, 16'd5, 16'd6, 16'd7, 16'd8};
      check_seq("t2");
      @(negedge clk);
      chk("t2_idle_busy", {31'h0, busy}, 32'h0);
      chk("t2_hold_data", {16'h0, tx_data}, 32'h0008);

      // Asynchronous reset in the middle of a payload
      src_req = 2'b01;
      repeat (4) @(negedge clk);
      chk("t1_busy_before", {31'h0, busy}, 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("t1_tx_en", {31'h0, tx_en}, 32'h0);
      chk("t1_grant", {30'h0, grant}, 32'h0);
      chk("t1_busy", {31'h0, busy}, 32'h0);
      chk("t1_pkt", {16'h0, pkt_count}, 32'h0);
      chk("t1_tx_data", {16'h0, tx_data}, 32'h0);
      src_req = 2'b00;
      @(negedge clk);
      rst = 1'b0;

      // Two contending sources alternate
      @(negedge clk);
      base    = cap.size();
      src_req = 2'b11;
      wait_pkt("t3", 16'd4, 80, 1'b0);
      src_req = 2'b00;
      exp_q = '{16'hA000, 16'd1, 16'd2, 16'd3, 16'd4,
                16'hA100, 16'h1001, 16'h1002, 16'h1003, 16'h1004,
                16'hA001, 16'd5, 16'd6, 16'd7, 16'd8,
                16'hA101, 16'h1005, 16'h1006, 16'h1007, 16'h1008};
      check_seq("t3");
      chk("t3_g0", {30'h0, gcap[base]}, 32'h1);
      chk("t3_g1", {30'h0, gcap[base + 5]}, 32'h2);
      chk("t3_g2", {30'h0, gcap[base + 10]}, 32'h1);
      chk("t3_g3", {30'h0, gcap[base + 15]}, 32'h2);

      // FIFO full toggling every cycle
      @(negedge clk);
      base    = cap.size();
      src_req = 2'b01;
      wait_pkt("t4", 16'd5, 60, 1'b1);
      src_req = 2'b00;
      tx_full = 1'b0;
      exp_q = '{16'hA002, 16'd9, 16'd10, 16'd11, 16'd12};
      check_seq("t4");

      // Valid gaps and enable dropped mid-packet
      @(negedge clk);
      base    = cap.size();
      src_req = 2'b10;
      repeat (2) @(negedge clk);
      chk("t5_busy", {31'h0, busy}, 32'h1);
      enable  = 1'b0;
      src_req = 2'b00;
      for (int c = 0; c < 60 && pkt_count !== 16'd6; c++) begin
         @(negedge clk);
         src_valid[1] = ~src_valid[1];
      end
      chk("t5_pkt", {16'h0, pkt_count}, 32'd6);
      src_valid = 2'b11;
      exp_q = '{16'hA102, 16'h1009, 16'h100A, 16'h100B, 16'h100C};
      check_seq("t5");
      base    = cap.size();
      src_req = 2'b11;
      repeat (5) @(negedge clk);
      chk("t5_hold_busy", {31'h0, busy}, 32'h0);
      chk("t5_hold_grant", {30'h0, grant}, 32'h0);
      chk("t5_hold_writes", 32'(cap.size() - base), 32'h0);
      enable = 1'b1;
      @(negedge clk);
      chk("t5_rr_grant", {30'h0, grant}, 32'h1);

      // 256 packets from source 1: sequence number wraps
      rst = 1'b1;
      @(negedge clk);
      rst     = 1'b0;
      src_req = 2'b10;
      base    = cap.size();
      wait_pkt("t6", 16'd256, 2000, 1'b0);
      chk("t6_len", 32'(cap.size() - base), 32'd1280);
      chk("t6_first_hdr", {16'h0, cap[base]}, 32'hA100);
      chk("t6_last_hdr", {16'h0, cap[base + 1275]}, 32'hA1FF);
      chk("t6_last_word", {16'h0, cap[base + 1279]}, 32'h1400);
      @(negedge clk);
      chk("t6_wrap_en", {31'h0, tx_en}, 32'h1);
      chk("t6_wrap_hdr", {16'h0, tx_data}, 32'hA100);
      src_req = 2'b00;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
